cpu_run_ctl: RTL and testbench
==============================

CPU_RUN_CTL -- requirements
Module: cpu_run_ctl

Interface
REQ-001 Parameter RSTCYC, default 4: cycles cpu_n_rst is held low per reset command (range 1..255).
REQ-002 Parameter CNTBITS, default 32: width of the enabled-cycle counter.
REQ-003 Clock and reset: one clock; reset is asynchronous and active-low.
REQ-004 clk  in  1  system clock, all state on rising edge.
REQ-005 n_rst  in  1  asynchronous active-low reset.
REQ-006 cpuhalt  in  1  halt request level, held by requester until acklast.
REQ-007 cpustart  in  1  start (free-run) request level, held until acklast.
REQ-008 cpustep  in  1  single-step request level, held until acklast.
REQ-009 cpurst  in  1  CPU reset request level, held until acklast.
REQ-010 retire  in  1  one-cycle pulse from CPU per completed instruction.
REQ-011 pc  in  20  address of the instruction retiring with retire.
REQ-012 bpen  in  1  breakpoint enable.
REQ-013 bpaddr  in  20  breakpoint address.
REQ-014 acklast  out  1  one-cycle pulse: current request consumed.
REQ-015 cpuen  out  1  CPU clock enable.
REQ-016 cpu_n_rst  out  1  active-low CPU reset.
REQ-017 running  out  1  high in RUN state.
REQ-018 bphit  out  1  sticky: halted by breakpoint.
REQ-019 cyccnt  out  CNTBITS  count of cycles with cpuen high.

Function
REQ-020 States: HALT, RUN, STEP, RESET; cpuen high exactly in RUN and STEP; cpu_n_rst low exactly in RESET.
REQ-021 A request is taken only when acklast is low in that cycle; requests present while acklast is high are ignored.
REQ-022 Simultaneous requests priority: cpurst > cpuhalt > cpustep > cpustart; lower requests stay pending.
REQ-023 cpurst from any state: enter RESET, load reset counter with RSTCYC, clear cyccnt and bphit; aborts an in-progress step.
REQ-024 RESET: decrement counter each cycle; on reaching 0 go to HALT and pulse acklast in the same cycle as the transition.
REQ-025 cpuhalt: RUN or STEP -> HALT next cycle, acklast pulse next cycle; in HALT, acklast pulse only (no-op).
REQ-026 cpustart: HALT -> RUN next cycle, clear bphit, acklast pulse next cycle; in RUN, acklast only.
REQ-027 cpustep in HALT: enter STEP; acklast pulses the cycle after the first retire, when STEP -> HALT.
REQ-028 cpustep in RUN: acklast only, state unchanged.
REQ-029 Breakpoint: in RUN, retire && bpen && pc==bpaddr -> HALT next cycle, set bphit; no acklast.
REQ-030 Breakpoint is not evaluated in STEP; a step onto bpaddr does not set bphit.
REQ-031 Breakpoint and cpuhalt in the same cycle: go to HALT, set bphit, pulse acklast.
REQ-032 cyccnt increments by 1 every cycle cpuen is high, wraps modulo 2^CNTBITS.
REQ-033 retire outside RUN/STEP is ignored.

Reset
REQ-034 On n_rst low: state HALT, acklast 0, cpuen 0, cpu_n_rst 0, running 0, bphit 0, cyccnt 0, reset counter 0.
REQ-035 On n_rst release: cpu_n_rst goes high on the first clk edge; the block stays in HALT.

Structure
REQ-036 State encodings and RSTCYC/CNTBITS defaults live in a shared defines file, cpu_run_ctl_defs.
REQ-037 Single flat module, no sub-modules; a single always block for state, with outputs registered.

Verification
REQ-038 Reset, then cpurst held: cpu_n_rst low 4 cycles, acklast pulses once on the return to HALT, cyccnt=0.
REQ-039 cpustart, 10 cycles, cpuhalt: acklast twice, cpuen high 10 cycles, cyccnt=10, running low after halt.
REQ-040 In HALT, cpustep with retire at +3 cycles: cpuen high 3 cycles, acklast on the cycle after retire, state HALT.
REQ-041 bpen=1, bpaddr=0x00010, RUN, retire with pc=0x00010: HALT next cycle, bphit=1, no acklast; next cpustart clears bphit.
REQ-042 cpurst and cpuhalt asserted together during STEP: step aborted, RESET taken first; cpuhalt then acked as a no-op in HALT.
REQ-043 cyccnt with CNTBITS=4, 17 enabled cycles: cyccnt=1.

Source files
------------

// File: rtl/cpu_run_ctl_pkg.sv
// Shared definitions for the CPU run controller: state and request encodings,
// default parameter values and small decode helpers.
package cpu_run_ctl_defs;

  localparam int unsigned RSTCYC_DEF  = 4;
  localparam int unsigned CNTBITS_DEF = 32;
  localparam int unsigned PC_W        = 20;
  localparam int unsigned RCNT_W      = 8;

  typedef enum logic [1:0] {
    ST_HALT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_STEP  = 2'd2,
    ST_RESET = 2'd3
  } run_state_t;

  typedef enum logic [2:0] {
    REQ_NONE,
    REQ_RST,
    REQ_HALT,
    REQ_STEP,
    REQ_START
  } req_t;

  // Fixed priority: reset beats halt beats step beats start.
  function automatic req_t pick_req(input logic rst, input logic halt,
                                    input logic step, input logic start);
    if (rst)   return REQ_RST;
    if (halt)  return REQ_HALT;
    if (step)  return REQ_STEP;
    if (start) return REQ_START;
    return REQ_NONE;
  endfunction

  function automatic logic cpu_enabled(input run_state_t s);
    return (s == ST_RUN) || (s == ST_STEP);
  endfunction

endpackage

// File: rtl/cpu_run_ctl_if.sv
// Request/acknowledge handshake between a debug requester and the run controller.
interface cpu_run_ctl_if;
  logic cpuhalt;
  logic cpustart;
  logic cpustep;
  logic cpurst;
  logic acklast;

  modport master (output cpuhalt, output cpustart, output cpustep, output cpurst,
                  input acklast);
  modport slave  (input cpuhalt, input cpustart, input cpustep, input cpurst,
                  output acklast);
endinterface

// File: rtl/cpu_run_ctl.sv
// CPU run controller: halt/run/single-step/reset sequencing with breakpoint
// detection and an enabled-cycle counter. All outputs are registered.
module cpu_run_ctl
  import cpu_run_ctl_defs::*;
#(
  parameter int unsigned RSTCYC  = RSTCYC_DEF,
  parameter int unsigned CNTBITS = CNTBITS_DEF
) (
  input  logic               clk,
  input  logic               n_rst,
  cpu_run_ctl_if.slave       req,
  input  logic               retire,
  input  logic [PC_W-1:0]    pc,
  input  logic               bpen,
  input  logic [PC_W-1:0]    bpaddr,
  output logic               cpuen,
  output logic               cpu_n_rst,
  output logic               running,
  output logic               bphit,
  output logic [CNTBITS-1:0] cyccnt
);

  run_state_t        state;
  run_state_t        nxt_state;
  logic [RCNT_W-1:0] rst_cnt;
  logic [RCNT_W-1:0] rst_cnt_nxt;
  logic              ack_nxt;
  logic              bphit_nxt;
  logic              clr_cnt;
  logic              bp_match;
  req_t              taken;

  // Requests arriving during the acknowledge cycle are stale and ignored.
  assign taken    = req.acklast ? REQ_NONE
                                : pick_req(req.cpurst, req.cpuhalt, req.cpustep, req.cpustart);
  assign bp_match = retire && bpen && (pc == bpaddr);

  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    nxt_state   = state;
    rst_cnt_nxt = rst_cnt;
    ack_nxt     = 1'b0;
    bphit_nxt   = bphit;
    clr_cnt     = 1'b0;

    if (taken == REQ_RST && state != ST_RESET) begin
      nxt_state   = ST_RESET;
      rst_cnt_nxt = RCNT_W'(RSTCYC);
      bphit_nxt   = 1'b0;
      clr_cnt     = 1'b1;
    end else begin
      case (state)
        ST_HALT: begin
          case (taken)
            REQ_HALT:  ack_nxt = 1'b1;
            REQ_STEP:  nxt_state = ST_STEP;
            REQ_START: begin
              nxt_state = ST_RUN;
              ack_nxt   = 1'b1;
              bphit_nxt = 1'b0;
            end
            default: ;
          endcase
        end

        ST_RUN: begin
          // Step and start are accepted as no-ops while free-running.
          ack_nxt = (taken != REQ_NONE);
          if (taken == REQ_HALT) nxt_state = ST_HALT;
          if (bp_match) begin
            nxt_state = ST_HALT;
            bphit_nxt = 1'b1;
          end
        end

        ST_STEP: begin
          // Step/start stay pending until the step completes; no breakpoint here.
          if (taken == REQ_HALT || retire) begin
            nxt_state = ST_HALT;
            ack_nxt   = 1'b1;
          end
        end

        ST_RESET: begin
          if (rst_cnt <= RCNT_W'(1)) begin
            nxt_state   = ST_HALT;
            rst_cnt_nxt = '0;
            ack_nxt     = 1'b1;
          end else begin
            rst_cnt_nxt = rst_cnt - RCNT_W'(1);
          end
        end

        default: nxt_state = ST_HALT;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the values from before the edge.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state       <= ST_HALT;
      rst_cnt     <= '0;
      req.acklast <= 1'b0;
      cpuen       <= 1'b0;
      cpu_n_rst   <= 1'b0;
      running     <= 1'b0;
      bphit       <= 1'b0;
      cyccnt      <= '0;
    end else begin
      state       <= nxt_state;
      rst_cnt     <= rst_cnt_nxt;
      req.acklast <= ack_nxt;
      cpuen       <= cpu_enabled(nxt_state);
      cpu_n_rst   <= (nxt_state != ST_RESET);
      running     <= (nxt_state == ST_RUN);
      bphit       <= bphit_nxt;
      if (clr_cnt)    cyccnt <= '0;
      else if (cpuen) cyccnt <= cyccnt + CNTBITS'(1);
    end
  end

endmodule

// File: tb/tb_cpu_run_ctl.sv
// Self-checking bench for cpu_run_ctl: directed scenarios plus randomized
// run/step sessions scored against a transaction-level model.
module tb_cpu_run_ctl;

  logic        clk = 1'b0;
  logic        n_rst;
  logic        retire;
  logic [19:0] pc;
  logic        bpen;
  logic [19:0] bpaddr;

  logic        cpuen, cpu_n_rst, running, bphit;
  logic [31:0] cyccnt;
  logic        cpuen4, cpu_n_rst4, running4, bphit4;
  logic [3:0]  cyccnt4;

  cpu_run_ctl_if rq ();
  cpu_run_ctl_if rq4 ();

  always #5 clk = ~clk;

  cpu_run_ctl #(.RSTCYC(4), .CNTBITS(32)) dut (
    .clk(clk), .n_rst(n_rst), .req(rq.slave), .retire(retire), .pc(pc),
    .bpen(bpen), .bpaddr(bpaddr), .cpuen(cpuen), .cpu_n_rst(cpu_n_rst),
    .running(running), .bphit(bphit), .cyccnt(cyccnt)
  );

  cpu_run_ctl #(.RSTCYC(4), .CNTBITS(4)) dut4 (
    .clk(clk), .n_rst(n_rst), .req(rq4.slave), .retire(retire), .pc(pc),
    .bpen(bpen), .bpaddr(bpaddr), .cpuen(cpuen4), .cpu_n_rst(cpu_n_rst4),
    .running(running4), .bphit(bphit4), .cyccnt(cyccnt4)
  );

  int passed = 0;
  int total  = 0;

  // Transaction-level model: is the CPU enabled, cycles enabled so far, sticky bphit.
  bit          model_en  = 1'b0;
  logic [31:0] exp_cyc   = '0;
  bit          exp_bphit = 1'b0;

  task automatic tick();
    @(posedge clk);
    if (model_en) exp_cyc++;
    @(negedge clk);
  endtask

  task automatic test_reset();
    total++; if (rq.acklast !== 1'b0) $display("FAIL rst_ack got=%0b exp=0", rq.acklast); else passed++;
    total++; if (cpuen !== 1'b0) $display("FAIL rst_cpuen got=%0b exp=0", cpuen); else passed++;
    total++; if (cpu_n_rst !== 1'b0) $display("FAIL rst_cpu_n_rst got=%0b exp=0", cpu_n_rst); else passed++;
    total++; if (running !== 1'b0) $display("FAIL rst_running got=%0b exp=0", running); else passed++;
    total++; if (bphit !== 1'b0) $display("FAIL rst_bphit got=%0b exp=0", bphit); else passed++;
    total++; if (cyccnt !== 32'd0) $display("FAIL rst_cyccnt got=%0d exp=0", cyccnt); else passed++;
    n_rst = 1'b1;
    tick();
    total++; if (cpu_n_rst !== 1'b1) $display("FAIL rel_cpu_n_rst got=%0b exp=1", cpu_n_rst); else passed++;
    total++; if (cpuen !== 1'b0 || running !== 1'b0) $display("FAIL rel_halt cpuen=%0b running=%0b exp=0/0", cpuen, running); else passed++;
  endtask

  task automatic test_cpurst_held();
    int low = 0, acks = 0, ack_idx = -1;
    rq.cpurst = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (i == 0) exp_cyc = '0;
      if (!cpu_n_rst) low++;
      if (rq.acklast) begin
        acks++;
        if (ack_idx < 0) ack_idx = i;
        rq.cpurst = 1'b0;
      end
    end
    rq.cpurst = 1'b0;
    total++; if (low != 4) $display("FAIL cpurst_low_cycles got=%0d exp=4", low); else passed++;
    total++; if (acks != 1) $display("FAIL cpurst_acks got=%0d exp=1", acks); else passed++;
    total++; if (ack_idx != 4) $display("FAIL cpurst_ack_cycle got=%0d exp=4", ack_idx); else passed++;
    total++; if (cyccnt !== exp_cyc) $display("FAIL cpurst_cyccnt got=%0d exp=%0d", cyccnt, exp_cyc); else passed++;
  endtask

  task automatic test_start_halt();
    int en = 0, acks = 0;
    rq.cpustart = 1'b1;
    tick(); model_en = 1'b1;
    rq.cpustart = 1'b0;
    total++; if (running !== 1'b1) $display("FAIL start_running got=%0b exp=1", running); else passed++;
    if (cpuen) en++;
    if (rq.acklast) acks++;
    for (int i = 0; i < 9; i++) begin
      tick();
      if (cpuen) en++;
      if (rq.acklast) acks++;
    end
    rq.cpuhalt = 1'b1;
    tick(); model_en = 1'b0;
    rq.cpuhalt = 1'b0;
    if (cpuen) en++;
    if (rq.acklast) acks++;
    total++; if (acks != 2) $display("FAIL sh_acks got=%0d exp=2", acks); else passed++;
    total++; if (en != 10) $display("FAIL sh_cpuen_cycles got=%0d exp=10", en); else passed++;
    total++; if (cyccnt !== exp_cyc) $display("FAIL sh_cyccnt got=%0d exp=%0d", cyccnt, exp_cyc); else passed++;
    total++; if (running !== 1'b0) $display("FAIL sh_running got=%0b exp=0", running); else passed++;
    tick();
    total++; if (rq.acklast !== 1'b0) $display("FAIL sh_ack_single got=%0b exp=0", rq.acklast); else passed++;
  endtask

  task automatic test_step();
    int en = 0, acks = 0;
    bpen = 1'b1; bpaddr = 20'h00010;
    rq.cpustep = 1'b1;
    tick(); model_en = 1'b1;
    total++; if (cpuen !== 1'b1 || running !== 1'b0) $display("FAIL step_enter cpuen=%0b running=%0b exp=1/0", cpuen, running); else passed++;
    for (int i = 0; i < 3; i++) begin
      if (cpuen) en++;
      if (rq.acklast) acks++;
      if (i == 2) begin retire = 1'b1; pc = 20'h00010; end
      else tick();
    end
    tick(); model_en = 1'b0;
    retire = 1'b0;
    total++; if (en != 3 || acks != 0) $display("FAIL step_cycles en=%0d acks=%0d exp=3/0", en, acks); else passed++;
    total++; if (rq.acklast !== 1'b1) $display("FAIL step_ack got=%0b exp=1", rq.acklast); else passed++;
    total++; if (cpuen !== 1'b0) $display("FAIL step_halt got=%0b exp=0", cpuen); else passed++;
    total++; if (bphit !== exp_bphit) $display("FAIL step_no_bp got=%0b exp=%0b", bphit, exp_bphit); else passed++;
    rq.cpustep = 1'b0;
    tick();
    retire = 1'b1; pc = 20'h00010;
    tick();
    retire = 1'b0;
    total++; if (cpuen !== 1'b0 || rq.acklast !== 1'b0) $display("FAIL halt_retire cpuen=%0b ack=%0b exp=0/0", cpuen, rq.acklast); else passed++;
    total++; if (cyccnt !== exp_cyc) $display("FAIL step_cyccnt got=%0d exp=%0d", cyccnt, exp_cyc); else passed++;
  endtask

  task automatic test_breakpoint();
    bpen = 1'b1; bpaddr = 20'h00010;
    rq.cpustart = 1'b1;
    tick(); model_en = 1'b1;
    rq.cpustart = 1'b0;
    retire = 1'b1; pc = 20'h0000F;
    tick();
    total++; if (running !== 1'b1) $display("FAIL bp_nomatch running=%0b exp=1", running); else passed++;
    pc = 20'h00010;
    tick(); model_en = 1'b0; exp_bphit = 1'b1;
    retire = 1'b0;
    total++; if (running !== 1'b0 || cpuen !== 1'b0) $display("FAIL bp_halt running=%0b cpuen=%0b exp=0/0", running, cpuen); else passed++;
    total++; if (bphit !== 1'b1) $display("FAIL bp_sticky got=%0b exp=1", bphit); else passed++;
    total++; if (rq.acklast !== 1'b0) $display("FAIL bp_no_ack got=%0b exp=0", rq.acklast); else passed++;
    tick();
    total++; if (bphit !== 1'b1 || running !== 1'b0) $display("FAIL bp_hold bphit=%0b running=%0b exp=1/0", bphit, running); else passed++;
    rq.cpustart = 1'b1;
    tick(); model_en = 1'b1; exp_bphit = 1'b0;
    rq.cpustart = 1'b0;
    total++; if (bphit !== 1'b0 || rq.acklast !== 1'b1) $display("FAIL bp_restart bphit=%0b ack=%0b exp=0/1", bphit, rq.acklast); else passed++;
    tick();
    retire = 1'b1; pc = 20'h00010; rq.cpuhalt = 1'b1;
    tick(); model_en = 1'b0; exp_bphit = 1'b1;
    retire = 1'b0; rq.cpuhalt = 1'b0;
    total++; if (running !== 1'b0 || bphit !== 1'b1 || rq.acklast !== 1'b1) $display("FAIL bp_and_halt running=%0b bphit=%0b ack=%0b exp=0/1/1", running, bphit, rq.acklast); else passed++;
    total++; if (cyccnt !== exp_cyc) $display("FAIL bp_cyccnt got=%0d exp=%0d", cyccnt, exp_cyc); else passed++;
    tick();
  endtask

  task automatic test_step_abort();
    bit got = 1'b0;
    rq.cpustep = 1'b1;
    tick(); model_en = 1'b1;
    tick();
    total++; if (cpuen !== 1'b1) $display("FAIL abort_in_step cpuen=%0b exp=1", cpuen); else passed++;
    rq.cpurst = 1'b1; rq.cpuhalt = 1'b1;
    tick(); model_en = 1'b0; exp_cyc = '0; exp_bphit = 1'b0;
    total++; if (cpu_n_rst !== 1'b0 || cpuen !== 1'b0 || rq.acklast !== 1'b0) $display("FAIL abort_reset_first n_rst=%0b cpuen=%0b ack=%0b exp=0/0/0", cpu_n_rst, cpuen, rq.acklast); else passed++;
    for (int i = 0; i < 10 && !got; i++) begin
      tick();
      if (rq.acklast) got = 1'b1;
    end
    total++; if (!got) $display("FAIL abort_reset_ack timeout got=0 exp=1"); else passed++;
    rq.cpurst = 1'b0; rq.cpustep = 1'b0;
    total++; if (cpu_n_rst !== 1'b1) $display("FAIL abort_reset_done n_rst=%0b exp=1", cpu_n_rst); else passed++;
    tick();
    total++; if (rq.acklast !== 1'b0) $display("FAIL abort_gap ack=%0b exp=0", rq.acklast); else passed++;
    tick();
    rq.cpuhalt = 1'b0;
    total++; if (rq.acklast !== 1'b1 || cpuen !== 1'b0 || running !== 1'b0) $display("FAIL abort_halt_noop ack=%0b cpuen=%0b running=%0b exp=1/0/0", rq.acklast, cpuen, running); else passed++;
    total++; if (cyccnt !== exp_cyc || bphit !== exp_bphit) $display("FAIL abort_clear cyccnt=%0d bphit=%0b exp=%0d/%0b", cyccnt, bphit, exp_cyc, exp_bphit); else passed++;
    tick();
  endtask

  task automatic test_random();
    for (int it = 0; it < 40; it++) begin
      bpen   = 1'($urandom_range(0, 1));
      bpaddr = 20'($urandom_range(0, 3));
      if ($urandom_range(0, 2) != 0) begin
        int n = $urandom_range(1, 12);
        bit hit = 1'b0;
        rq.cpustart = 1'b1;
        tick(); model_en = 1'b1; exp_bphit = 1'b0;
        rq.cpustart = 1'b0;
        total++; if (rq.acklast !== 1'b1 || running !== 1'b1) $display("FAIL rnd_start it=%0d ack=%0b running=%0b exp=1/1", it, rq.acklast, running); else passed++;
        for (int j = 0; j < n && !hit; j++) begin
          retire = ($urandom_range(0, 2) == 0);
          pc     = 20'($urandom_range(0, 5));
          tick();
          if (retire && bpen && pc == bpaddr) begin
            hit = 1'b1; model_en = 1'b0; exp_bphit = 1'b1;
            total++; if (running !== 1'b0 || rq.acklast !== 1'b0) $display("FAIL rnd_bp it=%0d running=%0b ack=%0b exp=0/0", it, running, rq.acklast); else passed++;
          end
        end
        retire = 1'b0;
        if (!hit) begin
          rq.cpuhalt = 1'b1;
          tick(); model_en = 1'b0;
          rq.cpuhalt = 1'b0;
          total++; if (rq.acklast !== 1'b1) $display("FAIL rnd_halt_ack it=%0d got=%0b exp=1", it, rq.acklast); else passed++;
        end
      end else begin
        int k = $urandom_range(0, 4);
        rq.cpustep = 1'b1;
        tick(); model_en = 1'b1;
        for (int j = 0; j < k; j++) tick();
        retire = 1'b1; pc = bpaddr;
        tick(); model_en = 1'b0;
        retire = 1'b0; rq.cpustep = 1'b0;
        total++; if (rq.acklast !== 1'b1 || cpuen !== 1'b0) $display("FAIL rnd_step it=%0d ack=%0b cpuen=%0b exp=1/0", it, rq.acklast, cpuen); else passed++;
      end
      total++; if (running !== 1'b0 || bphit !== exp_bphit) $display("FAIL rnd_state it=%0d running=%0b bphit=%0b exp=0/%0b", it, running, bphit, exp_bphit); else passed++;
      total++; if (cyccnt !== exp_cyc) $display("FAIL rnd_cyccnt it=%0d got=%0d exp=%0d", it, cyccnt, exp_cyc); else passed++;
      tick();
    end
  endtask

  task automatic test_wrap();
    logic [3:0] exp4;
    rq4.cpustart = 1'b1;
    tick();
    rq4.cpustart = 1'b0;
    total++; if (cpuen4 !== 1'b1) $display("FAIL wrap_start cpuen=%0b exp=1", cpuen4); else passed++;
    for (int i = 0; i < 16; i++) tick();
    rq4.cpuhalt = 1'b1;
    tick();
    rq4.cpuhalt = 1'b0;
    exp4 = 4'(17 % 16);
    total++; if (cyccnt4 !== exp4 || cpuen4 !== 1'b0) $display("FAIL wrap_cyccnt got=%0d cpuen=%0b exp=%0d/0", cyccnt4, cpuen4, exp4); else passed++;
    tick();
  endtask

  initial begin
    n_rst = 1'b0;
    retire = 1'b0; pc = '0; bpen = 1'b0; bpaddr = '0;
    rq.cpuhalt = 1'b0; rq.cpustart = 1'b0; rq.cpustep = 1'b0; rq.cpurst = 1'b0;
    rq4.cpuhalt = 1'b0; rq4.cpustart = 1'b0; rq4.cpustep = 1'b0; rq4.cpurst = 1'b0;
    repeat (2) @(negedge clk);
    test_reset();
    test_cpurst_held();
    test_start_halt();
    test_step();
    test_breakpoint();
    test_step_abort();
    test_random();
    test_wrap();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
